// File: rtl/turn_sequencer_pkg.sv
// Shared constants for the turn sequencer: FSM state codes, player codes and
// the player-rotation helper.
package turn_sequencer_pkg;

  localparam int TILE_W_DEF = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_REVEAL = 3'd2;
  localparam logic [2:0] ST_STEP   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P1     = 2'd1;
  localparam logic [1:0] P2     = 2'd2;
  localparam logic [1:0] P3     = 2'd3;

  // Rotation wraps the last player back to P1, so P_NONE never reappears.
  function automatic logic [1:0] next_player(input logic [1:0] t, input int num);
    logic [1:0] last;
    last = 2'(num);
    if (t >= last) return P1;
    return t + 2'd1;
  endfunction

endpackage

// File: rtl/turn_sequencer_edge_detect.sv
// Rising-edge pulse generator for the (already synchronized) flip button.
module turn_sequencer_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= sig_i;
  end

  assign pulse_o = sig_i & ~prev_q;

endmodule

// File: rtl/turn_sequencer.sv
// Turn/step sequencer feeding the win checker: shows a flipped tile, then
// either steps the current player (B) or passes the turn; freezes on a win.
module turn_sequencer
  import turn_sequencer_pkg::*;
#(
  parameter int TILE_W        = TILE_W_DEF,
  parameter int REVEAL_CYCLES = 8,
  parameter int NUM_PLAYERS   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flip_btn,
  input  logic [TILE_W-1:0] tile_sel,
  input  logic [TILE_W-1:0] tile_pic,
  input  logic [TILE_W-1:0] target_pic,
  input  logic              W,
  output logic [1:0]        T,
  output logic              B,
  output logic              reveal_valid,
  output logic [TILE_W-1:0] reveal_tile,
  output logic              game_over,
  output logic [2:0]        state_o
);

  // Handshake: none. flip_btn is a level; only its rising edge (one-cycle
  // pulse) is acted on, and only in IDLE or WAIT. B is a one-cycle strobe
  // with no back-pressure; the checker samples it on every cycle it is high.

  localparam int CNT_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REVEAL_CYCLES - 1);

  logic              flip_edge;
  logic [2:0]        state_q, state_d;
  logic [1:0]        t_q, t_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              match_q, match_d;
  logic              rv_q, rv_d;
  logic [TILE_W-1:0] rt_q, rt_d;
  logic              go_q, go_d;

  turn_sequencer_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (flip_btn),
    .pulse_o(flip_edge)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    rv_d    = rv_q;
    rt_d    = rt_q;
    go_d    = go_q;

    // A win outside CHECK ends the game at once; CHECK handles its own W.
    if (W && (state_q != ST_CHECK) && (state_q != ST_DONE)) begin
      state_d = ST_DONE;
      go_d    = 1'b1;
      rv_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flip_edge) begin
            t_d     = P1;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flip_edge) begin
            rt_d    = tile_sel;
            match_d = (tile_pic == target_pic);
            rv_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_REVEAL;
          end
        end
        ST_REVEAL: begin
          if (cnt_q == CNT_LAST) begin
            rv_d    = 1'b0;
            cnt_d   = '0;
            state_d = match_q ? ST_STEP : ST_NEXT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STEP: state_d = ST_CHECK;
        ST_CHECK: begin
          if (W) begin
            go_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_NEXT: begin
          t_d     = next_player(t_q, NUM_PLAYERS);
          state_d = ST_WAIT;
        end
        ST_DONE: go_d = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      t_q     <= P_NONE;
      cnt_q   <= '0;
      match_q <= 1'b0;
      rv_q    <= 1'b0;
      rt_q    <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      rv_q    <= rv_d;
      rt_q    <= rt_d;
      go_q    <= go_d;
    end
  end

  // B comes straight from the registered state, so it lasts exactly one cycle.
  assign B            = (state_q == ST_STEP);
  assign T            = t_q;
  assign reveal_valid = rv_q;
  assign reveal_tile  = rt_q;
  assign game_over    = go_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: match/miss flips, player wrap, held and
// bouncing buttons, win freeze and mid-sequence resets.
module tb_turn_sequencer;
  import turn_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flip_btn = 1'b0;
  logic       W = 1'b0;
  logic [3:0] tile_sel = '0;
  logic [3:0] tile_pic = '0;
  logic [3:0] target_pic = '0;
  logic [1:0] T;
  logic       B;
  logic       reveal_valid;
  logic [3:0] reveal_tile;
  logic       game_over;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int rv_cnt, b_cnt, b_consec;
  logic [1:0] t_at_b;
  logic       b_prev;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  turn_sequencer #(.TILE_W(4), .REVEAL_CYCLES(8), .NUM_PLAYERS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flip_btn    (flip_btn),
    .tile_sel    (tile_sel),
    .tile_pic    (tile_pic),
    .target_pic  (target_pic),
    .W           (W),
    .T           (T),
    .B           (B),
    .reveal_valid(reveal_valid),
    .reveal_tile (reveal_tile),
    .game_over   (game_over),
    .state_o     (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rv_cnt = 0; b_cnt = 0; b_consec = 0; t_at_b = '0; b_prev = 1'b0;
  endtask

  // One clock, then sample #1 after the edge and update the monitors.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reveal_valid) rv_cnt++;
    if (B) begin
      b_cnt++;
      if (b_prev) b_consec++;
      t_at_b = T;
    end
    b_prev = B;
  endtask

  task automatic flip(input logic [3:0] sel, input logic [3:0] pic, input logic [3:0] tgt, input int n);
    tile_sel = sel; tile_pic = pic; target_pic = tgt;
    flip_btn = 1'b1;
    tick();
    flip_btn = 1'b0;
    repeat (n - 1) tick();
  endtask

  task automatic start_game();
    flip_btn = 1'b1;
    tick();
    flip_btn = 1'b0;
    tick();
  endtask

  initial begin
    // Reset and idle
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_T", T, 2'd0);
    check_eq("rst_B", B, 1'b0);
    check_eq("rst_rv", reveal_valid, 1'b0);
    check_eq("rst_rt", reveal_tile, 4'd0);
    check_eq("rst_go", game_over, 1'b0);
    check_eq("rst_state", state, ST_IDLE);
    repeat (3) tick();
    check_eq("idle_T", T, 2'd0);

    // First edge only starts the game
    clear_mon();
    flip_btn = 1'b1;
    tick();
    check_eq("start_T", T, 2'd1);
    check_eq("start_B", B, 1'b0);
    check_eq("start_state", state, ST_WAIT);
    check_eq("start_rv", reveal_valid, 1'b0);
    flip_btn = 1'b0;
    tick();

    // Matching flip
    clear_mon();
    flip(4'h9, 4'd5, 4'd5, 12);
    check_eq("match_rv_cycles", rv_cnt, 8);
    check_eq("match_b_cnt", b_cnt, 1);
    check_eq("match_t_at_b", t_at_b, 2'd1);
    check_eq("match_T_after", T, 2'd1);
    check_eq("match_state", state, ST_WAIT);
    check_eq("match_rt", reveal_tile, 4'h9);

    // Three misses rotate 1->2->3->1
    exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd1);
    for (int i = 0; i < 3; i++) begin
      clear_mon();
      flip(4'(i + 1), 4'd3, 4'd7, 12);
      check_eq("miss_b_cnt", b_cnt, 0);
      check_eq("miss_rv_cycles", rv_cnt, 8);
      check_eq("miss_T", T, exp_q.pop_front());
    end

    // Button held 20 cycles: one reveal, one step
    clear_mon();
    tile_sel = 4'h2; tile_pic = 4'd5; target_pic = 4'd5;
    flip_btn = 1'b1;
    repeat (20) tick();
    flip_btn = 1'b0;
    repeat (3) tick();
    check_eq("held_rv_cycles", rv_cnt, 8);
    check_eq("held_b_cnt", b_cnt, 1);
    check_eq("held_b_consec", b_consec, 0);
    check_eq("held_T", T, 2'd1);

    // Extra edges during reveal and one coincident with reveal end
    clear_mon();
    tile_sel = 4'hA; tile_pic = 4'd6; target_pic = 4'd6;
    for (int i = 0; i < 14; i++) begin
      flip_btn = (i == 0) || (i == 2) || (i == 4) || (i == 8);
      if (i == 3) tile_sel = 4'h5;
      tick();
    end
    flip_btn = 1'b0;
    repeat (2) tick();
    check_eq("bounce_rv_cycles", rv_cnt, 8);
    check_eq("bounce_b_cnt", b_cnt, 1);
    check_eq("bounce_rt", reveal_tile, 4'hA);
    check_eq("bounce_state", state, ST_WAIT);

    // Win reported in CHECK freezes the game
    clear_mon();
    tile_sel = 4'h1; tile_pic = 4'd2; target_pic = 4'd2;
    for (int i = 0; i < 14; i++) begin
      flip_btn = (i == 0);
      W = (i == 10);
      tick();
    end
    W = 1'b0;
    check_eq("win_b_cnt", b_cnt, 1);
    check_eq("win_state", state, ST_DONE);
    check_eq("win_go", game_over, 1'b1);
    clear_mon();
    flip(4'h3, 4'd4, 4'd4, 12);
    flip(4'h4, 4'd1, 4'd9, 12);
    check_eq("done_b_cnt", b_cnt, 0);
    check_eq("done_T", T, 2'd1);
    check_eq("done_go", game_over, 1'b1);
    check_eq("done_state", state, ST_DONE);

    // Reset in the middle of a reveal
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    start_game();
    flip(4'h5, 4'd1, 4'd1, 4);
    check_eq("mid_rv", reveal_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    check_eq("rrev_T", T, 2'd0);
    check_eq("rrev_rv", reveal_valid, 1'b0);
    check_eq("rrev_B", B, 1'b0);
    check_eq("rrev_state", state, ST_IDLE);
    check_eq("rrev_rt", reveal_tile, 4'd0);
    rst_n = 1'b1;
    tick();

    // Reset while B is high drops the step
    start_game();
    flip(4'h6, 4'd8, 4'd8, 9);
    check_eq("pre_step_B", B, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (5) tick();
    check_eq("rstep_b_cnt", b_cnt, 0);
    check_eq("rstep_state", state, ST_IDLE);
    check_eq("rstep_T", T, 2'd0);

    // Win seen in WAIT ends the game immediately
    start_game();
    W = 1'b1;
    tick();
    W = 1'b0;
    check_eq("wwait_state", state, ST_DONE);
    check_eq("wwait_go", game_over, 1'b1);
    clear_mon();
    flip(4'h7, 4'd2, 4'd2, 12);
    check_eq("wwait_b_cnt", b_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
